// File: rtl/register_bank_pkg.sv
// register_bank_pkg
// Shared definitions for the register bank arbiter and its helpers:
//   - FSM state encoding (ST_ARB, ST_XFER)
//   - default register index / data widths
//   - regs_for(): number of registers addressed by a given index width
package register_bank_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 3;
  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  function automatic int regs_for(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/round_robin_pick.sv
// round_robin_pick
// Combinational round-robin selector. The search starts at index ptr and
// wraps, so the requester at ptr has the highest priority and ptr-1 the lowest.
// Ports:
//   req           in  NUM_REQ    request vector
//   ptr           in  IDX_WIDTH  highest-priority index
//   winner_onehot out NUM_REQ    one-hot selected requester (zero if none)
//   winner_index  out IDX_WIDTH  binary index of the selected requester
//   any           out 1          at least one request present
module round_robin_pick #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   winner_onehot,
  output logic [IDX_WIDTH-1:0] winner_index,
  output logic                 any
);

  always_comb begin
    logic [IDX_WIDTH-1:0] idx;
    idx           = '0;
    winner_onehot = '0;
    winner_index  = '0;
    any           = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDX_WIDTH'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        any                = 1'b1;
        winner_onehot[idx] = 1'b1;
        winner_index       = idx;
      end
    end
  end

endmodule

// File: rtl/register_bank_arbiter.sv
// register_bank_arbiter
// Serializes single read/write transactions from NUM_REQ requesters onto one
// shared bank of REGS registers, round-robin.
//
// Handshake: a requester raises req (level) with wr/addr/wdata valid. The
// cycle after it is sampled in ARB, grant shows the owner for exactly one
// XFER cycle; operands are latched at that point, so req may drop and the
// operands may change freely. The following cycle ack pulses once for the
// owner (with rdata valid for reads). A req still high during ack is a new
// request ranked lowest, since ptr has moved past that requester.
//
// Ports:
//   clock, nreset      clock, asynchronous active-low reset
//   req/wr/addr/wdata  per-requester transaction (addr/wdata flattened)
//   grant              one-hot owner during XFER, zero otherwise
//   ack                one-cycle completion pulse
//   rdata              read result, held between reads
//   busy               high in XFER
//   bank_write_enable  one-hot register write enable (flop-decoded)
//   bank_data_in       shared write data to the bank
//   bank_data_out      flattened bank contents
//   fsm_state          current FSM state, for observation
module register_bank_arbiter
  import register_bank_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  localparam int REGS      = regs_for(ADDR_WIDTH),
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       busy,
  output logic [REGS-1:0]            bank_write_enable,
  output logic [DATA_WIDTH-1:0]      bank_data_in,
  input  logic [REGS*DATA_WIDTH-1:0] bank_data_out,
  output state_t                     fsm_state
);

  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, win_q;
  logic [NUM_REQ-1:0]    win_oh_q, ack_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;

  logic [NUM_REQ-1:0]    pick_oh;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] bank_arr  [REGS];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_slices
    assign addr_arr[g]  = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar g = 0; g < REGS; g++) begin : g_bank_slices
    assign bank_arr[g] = bank_data_out[g*DATA_WIDTH +: DATA_WIDTH];
  end

  round_robin_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IW)
  ) u_pick (
    .req           (req),
    .ptr           (ptr_q),
    .winner_onehot (pick_oh),
    .winner_index  (pick_idx),
    .any           (pick_any)
  );

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state_q <= ST_ARB;
    else         state_q <= state_d;
  end

  // Next-state logic: XFER always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:  if (pick_any) state_d = ST_XFER;
      ST_XFER: state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Datapath: operand latch in ARB, completion bookkeeping when leaving XFER.
  // A reset mid-XFER clears ack_q before it can be set, so the dropped
  // transaction produces neither a write nor an ack.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ptr_q    <= '0;
      win_q    <= '0;
      win_oh_q <= '0;
      ack_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      ack_q <= '0;
      if (state_q == ST_ARB && pick_any) begin
        win_q    <= pick_idx;
        win_oh_q <= pick_oh;
        wr_q     <= wr[pick_idx];
        addr_q   <= addr_arr[pick_idx];
        wdata_q  <= wdata_arr[pick_idx];
      end
      if (state_q == ST_XFER) begin
        ack_q <= win_oh_q;
        ptr_q <= (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        if (!wr_q) rdata_q <= bank_arr[addr_q];
      end
    end
  end

  // Outputs decoded only from flops so the bank sees glitch-free enables
  always_comb begin
    grant             = '0;
    busy              = 1'b0;
    bank_write_enable = '0;
    if (state_q == ST_XFER) begin
      grant = win_oh_q;
      busy  = 1'b1;
      if (wr_q) bank_write_enable[addr_q] = 1'b1;
    end
  end

  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign bank_data_in = wdata_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_register_bank_arbiter.sv
// tb_register_bank_arbiter
// Self-checking bench: an external bank model driven by the DUT, directed
// request scenarios, and a scoreboard of expected completions (owner,
// direction, register, data) checked whenever ack pulses.
module tb_register_bank_arbiter;
  import register_bank_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int AW      = 3;
  localparam int DW      = 8;
  localparam int REGS    = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic nreset;
  always #5 clock = ~clock;

  logic [NUM_REQ-1:0]    req, wr;
  logic [NUM_REQ*AW-1:0] addr;
  logic [NUM_REQ*DW-1:0] wdata;
  logic [NUM_REQ-1:0]    grant, ack;
  logic [DW-1:0]         rdata;
  logic                  busy;
  logic [REGS-1:0]       bank_write_enable;
  logic [DW-1:0]         bank_data_in;
  logic [REGS*DW-1:0]    bank_data_out;
  state_t                fsm_state;

  register_bank_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clock             (clock),
    .nreset            (nreset),
    .req               (req),
    .wr                (wr),
    .addr              (addr),
    .wdata             (wdata),
    .grant             (grant),
    .ack               (ack),
    .rdata             (rdata),
    .busy              (busy),
    .bank_write_enable (bank_write_enable),
    .bank_data_in      (bank_data_in),
    .bank_data_out     (bank_data_out),
    .fsm_state         (fsm_state)
  );

  // Bank registers living above the arbiter (not reset by it)
  logic [DW-1:0] bank [REGS] = '{default: '0};
  always @(posedge clock)
    for (int i = 0; i < REGS; i++)
      if (bank_write_enable[i]) bank[i] <= bank_data_in;

  always_comb begin
    bank_data_out = '0;
    for (int i = 0; i < REGS; i++) bank_data_out[i*DW +: DW] = bank[i];
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // entry: [15:12] ack one-hot, [11] write, [10:8] register, [7:0] data
  logic [15:0]   exp_q[$];
  logic [DW-1:0] shadow [REGS] = '{default: '0};
  logic [DW-1:0] last_rd = '0;
  logic [3:0]    grant_log[$];
  logic [3:0]    prev_grant = '0;
  logic [15:0]   e;

  task automatic push_exp(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] v;
    if (w) begin
      shadow[a] = d;
      v = d;
    end else begin
      v = shadow[a];
    end
    exp_q.push_back({4'(1 << i), w, a, v});
  endtask

  always @(negedge clock) begin
    if (!nreset) begin
      prev_grant = '0;
    end else begin
      check_eq("grant_ack_overlap", 32'(grant & ack), 32'(0));
      check_eq("busy_vs_grant", 32'(busy), 32'(grant != 0));
      if (grant != 0) grant_log.push_back(grant);
      if (ack != 0) begin
        check_eq("ack_after_grant", 32'(ack), 32'(prev_grant));
        if (exp_q.size() == 0) begin
          check_eq("unexpected_ack", 32'(ack), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("ack_owner", 32'(ack), 32'(e[15:12]));
          if (e[11]) begin
            check_eq("bank_write", 32'(bank[e[10:8]]), 32'(e[7:0]));
            check_eq("rdata_hold", 32'(rdata), 32'(last_rd));
          end else begin
            check_eq("read_data", 32'(rdata), 32'(e[7:0]));
            last_rd = e[7:0];
          end
        end
      end
      prev_grant = grant;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]             = 1'b1;
    wr[i]              = w;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  // Each requester drops req once granted and scribbles over its operands,
  // which must not affect the latched transaction.
  task automatic run_idle(input int budget);
    int n = 0;
    do begin
      @(posedge clock); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          req[i]            = 1'b0;
          wr[i]             = 1'($urandom_range(0, 1));
          addr[i*AW +: AW]  = AW'($urandom_range(0, REGS - 1));
          wdata[i*DW +: DW] = DW'($urandom_range(0, 255));
        end
      end
      n++;
    end while ((req != 0 || grant != 0) && n < budget);
    if (req != 0 || grant != 0) check_eq("run_timeout", 32'(1), 32'(0));
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    nreset = 1'b0;
    req = '0; wr = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_grant", 32'(grant), 32'(0));
    check_eq("rst_ack", 32'(ack), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_bwe", 32'(bank_write_enable), 32'(0));
    check_eq("rst_rdata", 32'(rdata), 32'(0));
    check_eq("rst_data_in", 32'(bank_data_in), 32'(0));
    check_eq("rst_state", 32'(fsm_state), 32'(ST_ARB));
    nreset = 1'b1;

    // All four at once from reset: order 0,1,2,3
    grant_log.delete();
    set_req(0, 1'b1, 3'd1, 8'h21);
    set_req(1, 1'b0, 3'd1, 8'h00);
    set_req(2, 1'b1, 3'd2, 8'h42);
    set_req(3, 1'b0, 3'd3, 8'h00);
    for (int i = 0; i < 4; i++) push_exp(i, (i % 2) == 0, AW'(i == 0 ? 1 : i), i == 0 ? 8'h21 : 8'h42);
    run_idle(40);
    check_eq("all4_count", 32'(grant_log.size()), 32'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_eq("all4_order", 32'(grant_log[i]), 32'(1 << i));

    // Single write then read by requester 1, with cycle-exact timing
    set_req(1, 1'b1, 3'd3, 8'hA5);
    push_exp(1, 1'b1, 3'd3, 8'hA5);
    @(posedge clock); #1;
    check_eq("wr_grant", 32'(grant), 32'h2);
    check_eq("wr_bwe", 32'(bank_write_enable), 32'h08);
    check_eq("wr_data_in", 32'(bank_data_in), 32'hA5);
    req[1] = 1'b0;
    @(posedge clock); #1;
    check_eq("wr_ack", 32'(ack), 32'h2);
    check_eq("wr_bank3", 32'(bank[3]), 32'hA5);
    set_req(1, 1'b0, 3'd3, 8'h00);
    push_exp(1, 1'b0, 3'd3, 8'h00);
    run_idle(20);

    // Requester 3 withdraws req in XFER and changes its operands
    set_req(3, 1'b1, 3'd7, 8'h3C);
    push_exp(3, 1'b1, 3'd7, 8'h3C);
    @(posedge clock); #1;
    check_eq("wd_grant", 32'(grant), 32'h8);
    req[3] = 1'b0; wr[3] = 1'b0; addr[9 +: 3] = 3'd0; wdata[24 +: 8] = 8'hFF;
    @(posedge clock); #1;
    check_eq("wd_ack", 32'(ack), 32'h8);
    check_eq("wd_bank7", 32'(bank[7]), 32'h3C);
    @(posedge clock); #1;

    // Fairness: 0 and 2 hold req for 16 cycles
    grant_log.delete();
    set_req(0, 1'b0, 3'd5, 8'h00);
    set_req(2, 1'b1, 3'd5, 8'h5A);
    for (int k = 0; k < 4; k++) begin
      push_exp(0, 1'b0, 3'd5, 8'h00);
      push_exp(2, 1'b1, 3'd5, 8'h5A);
    end
    repeat (16) @(posedge clock);
    #1;
    req = '0;
    run_idle(10);
    check_eq("fair_count", 32'(grant_log.size()), 32'(8));
    for (int k = 0; k < grant_log.size(); k++) begin
      check_eq("fair_order", 32'(grant_log[k]), (k % 2 == 0) ? 32'h1 : 32'h4);
      if (k > 0) check_eq("fair_repeat", 32'(grant_log[k] == grant_log[k-1]), 32'(0));
    end

    // Back-to-back: requester 0 writes reg 5, requester 1 reads it next
    grant_log.delete();
    set_req(0, 1'b1, 3'd5, 8'h11);
    set_req(1, 1'b0, 3'd5, 8'h00);
    push_exp(0, 1'b1, 3'd5, 8'h11);
    push_exp(1, 1'b0, 3'd5, 8'h00);
    run_idle(20);
    check_eq("b2b_count", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() == 2) begin
      check_eq("b2b_first", 32'(grant_log[0]), 32'h1);
      check_eq("b2b_second", 32'(grant_log[1]), 32'h2);
    end

    // Reset mid-XFER: leave ptr at 2 and rdata nonzero first
    set_req(1, 1'b0, 3'd1, 8'h00);
    push_exp(1, 1'b0, 3'd1, 8'h00);
    run_idle(20);
    set_req(2, 1'b1, 3'd0, 8'hFF);
    @(posedge clock); #1;
    check_eq("rx_grant", 32'(grant), 32'h4);
    #1 nreset = 1'b0;
    #1;
    check_eq("rx_grant0", 32'(grant), 32'(0));
    check_eq("rx_ack0", 32'(ack), 32'(0));
    check_eq("rx_busy0", 32'(busy), 32'(0));
    check_eq("rx_bwe0", 32'(bank_write_enable), 32'(0));
    check_eq("rx_rdata0", 32'(rdata), 32'(0));
    check_eq("rx_data_in0", 32'(bank_data_in), 32'(0));
    check_eq("rx_state", 32'(fsm_state), 32'(ST_ARB));
    req[2] = 1'b0;
    last_rd = '0;
    @(posedge clock); #1;
    check_eq("rx_bank0", 32'(bank[0]), 32'(shadow[0]));
    check_eq("rx_noack", 32'(ack), 32'(0));
    #2 nreset = 1'b1;
    grant_log.delete();
    set_req(1, 1'b0, 3'd2, 8'h00);
    set_req(3, 1'b0, 3'd3, 8'h00);
    push_exp(1, 1'b0, 3'd2, 8'h00);
    push_exp(3, 1'b0, 3'd3, 8'h00);
    run_idle(20);
    check_eq("rx_first_grant", grant_log.size() > 0 ? 32'(grant_log[0]) : 32'(0), 32'h2);

    check_eq("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank_arbiter.md
# register_bank_arbiter

Round-robin arbiter and sequencer sharing one bank of 8-bit `register_byte` storage between several requesters. Each requester issues single read or write transactions. The arbiter serializes them and drives the bank's per-register write enables and shared data input. It returns read data and a one-cycle acknowledge to the winning requester. It sits between processor-side agents (e.g. decode/writeback, debug port) and the general-purpose register bank.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_WIDTH`, default 3: register index width; bank has `REGS = 2**ADDR_WIDTH` registers.
- `DATA_WIDTH`, default 8: register width.
- `clock`  in  1  single clock; all state changes on the posedge.
- `nreset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester transaction request, level.
- `wr`  in  NUM_REQ  per-requester direction; 1 = write, 0 = read; valid while `req` is high.
- `addr`  in  NUM_REQ*ADDR_WIDTH  flattened register index; requester i uses slice i.
- `wdata`  in  NUM_REQ*DATA_WIDTH  flattened write data; requester i uses slice i.
- `grant`  out  NUM_REQ  one-hot owner of the current transfer; zero when idle.
- `ack`  out  NUM_REQ  one-cycle pulse marking transaction completion.
- `rdata`  out  DATA_WIDTH  read result; valid in the `ack` cycle of a read.
- `busy`  out  1  high while in XFER.
- `bank_write_enable`  out  REGS  one-hot write enable to the bank registers.
- `bank_data_in`  out  DATA_WIDTH  shared write data to all bank registers.
- `bank_data_out`  in  REGS*DATA_WIDTH  flattened current contents of all bank registers.

## Operation
- Two-state FSM: ARB, XFER. Reset state is ARB.
- **ARB:** if any `req` bit is high, select a winner by round-robin starting at pointer `ptr`. Latch the winner's `wr`, `addr` and `wdata`. Set `grant` to the winner's one-hot bit and go to XFER. With no request, stay in ARB with `grant` = 0.
- **XFER:**
  - On a write, `bank_write_enable[addr_l]` = 1 and `bank_data_in` = latched data. The register captures the data on the edge that leaves XFER.
  - On a read, `rdata` is registered from slice `addr_l` of `bank_data_out`.
  - On leaving: pulse `ack[winner]`, clear `grant`, set `ptr` = (winner+1) mod NUM_REQ, return to ARB.
- `bank_write_enable` is zero in every state except XFER with a latched write. It is decoded only from flops, so it is glitch-free at the bank.
- **Requester drops `req` during XFER:** the transaction still completes and `ack` still pulses. Operands are latched, so changes to `addr`, `wr` or `wdata` after grant are ignored.
- **`req` still high in the `ack` cycle:** this is a new request. It competes at the lowest priority because `ptr` has moved past that requester.
- **Read of a register written by the immediately preceding transaction:** returns the new value, because the bank has already updated.
- **Reset (any time, including mid-XFER):**
  - Immediately: state = ARB; `grant`, `ack`, `busy`, `bank_write_enable` = 0.
  - Also cleared: `rdata` = 0, `bank_data_in` = 0, `ptr` = 0.
  - The in-flight transaction is dropped with no write and no `ack`.
- `rdata` holds its last value between reads.

## Timing
- Request sampled in ARB at cycle N: `grant` and `busy` high in cycle N+1 (XFER).
- A write is visible on `bank_data_out` in N+2. `ack` and read `rdata` are valid in N+2.
- Fixed latency of 2 cycles from request to ack when idle. Throughput is one transaction per 2 cycles; the `ack` cycle overlaps the next ARB.
- Worst-case wait is 2*(NUM_REQ-1) cycles beyond the base latency (starvation-free).
- `grant` and `ack` are never asserted in the same cycle.

## Structure
- Shared package `register_bank_pkg` holds:
  - the state encoding constants `ST_ARB` and `ST_XFER`;
  - default `ADDR_WIDTH` and `DATA_WIDTH`;
  - the `REGS` derivation.
- Sub-module `round_robin_pick`: combinational; inputs `req` and `ptr`; outputs `winner_onehot`, `winner_index` and `any`. It is reused by later bus arbiters.
- Bank of `REGS` register instances lives at the next level up. This block only drives and observes it.

## Test plan
- **Single write then read:** requester 1 writes 0xA5 to reg 3 at cycle 0. Expect `ack[1]` in cycle 2 and `bank_data_out` reg 3 = 0xA5. Then a reg 3 read returns `rdata` = 0xA5 with `ack[1]`.
- **All four request simultaneously from reset:** grants occur in order 0,1,2,3 every 2 cycles. Each `ack` appears exactly once, 1 cycle after its grant ends.
- **Fairness:** requesters 0 and 2 hold `req` continuously for 16 cycles. Grants alternate 0,2,0,2,… and neither is granted twice in a row.
- **Request withdrawn after grant:** requester 3 asserts a write of 0x3C to reg 7 and drops `req` in the XFER cycle. The write still lands (reg 7 = 0x3C) and `ack[3]` still pulses.
- **Reset mid-XFER:** during a write of 0xFF to reg 0, assert `nreset` low in the XFER cycle. All outputs go to 0 immediately, reg 0 is unchanged, and there is no `ack`. After release, the first grant goes to the lowest-index active requester (`ptr` = 0).
- **Back-to-back write/read of the same register by different requesters:** requester 0 writes 0x11 to reg 5, then requester 1 reads reg 5 and receives 0x11.
